// File: rtl/handshake_reg_pkg.sv
// Shared types for the valid/ready pipeline register.
package handshake_reg_pkg;

    // Occupancy states of the full-rate skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/handshake_reg.sv
// Single-channel valid/ready pipeline register; half-rate (FULL=0) or
// full-rate two-entry skid buffer (FULL!=0). inReady/outValid are flops.
module handshake_reg
    import handshake_reg_pkg::*;
#(
    parameter int unsigned FULL = 0,
    parameter int unsigned W    = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] dIn,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] dOut
);

    if (FULL != 0) begin : g_full
        hs_state_e     state_q;
        logic          vld_q;
        logic          rdy_q;
        logic [W-1:0]  main_q;
        logic [W-1:0]  skid_q;
        logic          in_xfer;
        logic          out_xfer;
        logic          load_main;
        logic          load_skid;
        logic          drain_skid;

        assign in_xfer    = inValid && rdy_q;
        assign out_xfer   = vld_q && outReady;
        // main takes the new word when it is empty or being emptied this edge
        assign load_main  = in_xfer && ((state_q == ST_EMPTY) || out_xfer);
        assign load_skid  = in_xfer && (state_q == ST_BUSY) && !out_xfer;
        assign drain_skid = (state_q == ST_FULL) && out_xfer;

        // Occupancy FSM; valid/ready flags are registered alongside the state.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                state_q <= ST_EMPTY;
                vld_q   <= 1'b0;
                rdy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        rdy_q <= 1'b1;
                        if (in_xfer) begin
                            state_q <= ST_BUSY;
                            vld_q   <= 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (in_xfer && !out_xfer) begin
                            state_q <= ST_FULL;
                            rdy_q   <= 1'b0;
                        end else if (!in_xfer && out_xfer) begin
                            state_q <= ST_EMPTY;
                            vld_q   <= 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (out_xfer) begin
                            state_q <= ST_BUSY;
                            rdy_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b0;
                    end
                endcase
            end
        end

        // Payload registers; not reset, contents are qualified by vld_q.
        always_ff @(posedge clk) begin
            if (load_main) begin
                main_q <= dIn;
            end else if (drain_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dIn;
            end
        end

        assign inReady  = rdy_q;
        assign outValid = vld_q;
        assign dOut     = main_q;
    end else begin : g_half
        logic          valid_q;
        logic          rdy_q;
        logic [W-1:0]  data_q;
        logic          load;

        assign load = rdy_q && inValid;

        // Single-entry flag; ready is the registered complement of valid,
        // held low through reset and released one edge later.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                valid_q <= 1'b0;
                rdy_q   <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
                rdy_q   <= 1'b0;
            end else if (valid_q && outReady) begin
                valid_q <= 1'b0;
                rdy_q   <= 1'b1;
            end else begin
                rdy_q   <= !valid_q;
            end
        end

        // Payload register; not reset.
        always_ff @(posedge clk) begin
            if (load) begin
                data_q <= dIn;
            end
        end

        assign inReady  = rdy_q;
        assign outValid = valid_q;
        assign dOut     = data_q;
    end

endmodule

// File: tb/tb_handshake_reg.sv
// Bench for handshake_reg: both modes side by side (index 0 half-rate,
// index 1 full-rate), checked against an occupancy/FIFO reference model.
module tb_handshake_reg;

    localparam int unsigned W = 36;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid  [2];
    logic          out_ready [2];
    logic [W-1:0]  din       [2];
    logic          in_ready  [2];
    logic          out_valid [2];
    logic [W-1:0]  dout      [2];

    int checks = 0;
    int errors = 0;

    // reference model: words held in arrival order, capacity 1 or 2
    logic [W-1:0]  mq [2][2];
    int            cnt [2];
    bit            in_rst [2];
    bit            acc [2];
    int            cyc = 0;
    bit            chk_en = 1'b0;

    // producer state
    int            left [2];
    logic [W-1:0]  nxt [2];
    bit            rnd_data = 1'b0;

    // output log taken from the DUT
    logic [W-1:0]  log_w [2][64];
    int            log_c [2][64];
    int            log_n [2];
    bit            rdy_drop [2];

    handshake_reg #(.FULL(0), .W(W)) u_half (
        .clk(clk), .rstn(rstn),
        .inValid(in_valid[0]), .inReady(in_ready[0]), .dIn(din[0]),
        .outValid(out_valid[0]), .outReady(out_ready[0]), .dOut(dout[0])
    );

    handshake_reg #(.FULL(1), .W(W)) u_full (
        .clk(clk), .rstn(rstn),
        .inValid(in_valid[1]), .inReady(in_ready[1]), .dIn(din[1]),
        .outValid(out_valid[1]), .outReady(out_ready[1]), .dOut(dout[1])
    );

    always #5 clk = ~clk;

    function automatic int cap(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic bit exp_ready(input int d);
        return !in_rst[d] && (cnt[d] < cap(d));
    endfunction

    task automatic check(input string name, input int d, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %h want %h", name, d, cyc, got, want);
        end
    endtask

    // model update on each edge from the handshake rules
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            bit er;
            bit ev;
            er = exp_ready(d);
            ev = cnt[d] > 0;
            acc[d] = 1'b0;
            if (!rstn) begin
                cnt[d] = 0;
                in_rst[d] = 1'b1;
            end else begin
                if (ev && out_ready[d]) begin
                    mq[d][0] = mq[d][1];
                    cnt[d]--;
                end
                if (er && in_valid[d]) begin
                    mq[d][cnt[d]] = din[d];
                    cnt[d]++;
                    acc[d] = 1'b1;
                end
                in_rst[d] = 1'b0;
            end
        end
    end

    // compare DUT against model mid-cycle; also log output transfers
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_en) begin
                check("in_ready", d, W'(in_ready[d]), W'(exp_ready(d)));
                check("out_valid", d, W'(out_valid[d]), W'(cnt[d] > 0));
                if (cnt[d] > 0) check("dout", d, dout[d], mq[d][0]);
            end
            if (out_valid[d] === 1'b1 && out_ready[d] && log_n[d] < 64) begin
                log_w[d][log_n[d]] = dout[d];
                log_c[d][log_n[d]] = cyc;
                log_n[d]++;
            end
            if (left[d] > 0 && in_ready[d] !== 1'b1) rdy_drop[d] = 1'b1;
        end
    end

    // one cycle of stimulus: pv/pr are valid/ready probabilities in percent
    task automatic step(input int pv, input int pr);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit held;
            held = in_valid[d] && !acc[d];
            if (acc[d]) begin
                if (left[d] > 0) left[d]--;
                nxt[d] = rnd_data ? W'({$urandom, $urandom}) : nxt[d] + W'(1);
            end
            in_valid[d]  = (left[d] > 0) && (held || ($urandom_range(99) < pv));
            din[d]       = nxt[d];
            out_ready[d] = $urandom_range(99) < pr;
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 400 && !(left[0] == 0 && left[1] == 0 && cnt[0] == 0 && cnt[1] == 0)) begin
            step(100, 100);
            i++;
        end
        check("drain_done", 0, W'(i < 400), W'(1));
    endtask

    task automatic start(input logic [W-1:0] base, input int n);
        for (int d = 0; d < 2; d++) begin
            left[d] = n;
            nxt[d] = base;
            log_n[d] = 0;
            rdy_drop[d] = 1'b0;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b1;
            out_ready[d] = 1'b0;
            din[d] = '0;
            cnt[d] = 0;
            in_rst[d] = 1'b1;
            left[d] = 0;
            nxt[d] = '0;
            log_n[d] = 0;
            rdy_drop[d] = 1'b0;
        end

        // reset held with inValid=1
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", d, W'(in_ready[d]), W'(0));
            check("rst_out_valid", d, W'(out_valid[d]), W'(0));
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rel_in_ready", d, W'(in_ready[d]), W'(1));
            check("rel_out_valid", d, W'(out_valid[d]), W'(0));
        end

        // streaming 0x01..0x10
        rnd_data = 1'b0;
        start(W'(1), 16);
        drain();
        for (int d = 0; d < 2; d++) begin
            check("stream_count", d, W'(log_n[d]), W'(16));
            for (int k = 0; k < 16 && k < log_n[d]; k++) begin
                check("stream_word", d, log_w[d][k], W'(k + 1));
                if (k > 0) check("stream_gap", d, W'(log_c[d][k] - log_c[d][k-1]), W'((d == 1) ? 1 : 2));
            end
        end
        check("stream_ready_held", 1, W'(rdy_drop[1]), W'(0));

        // backpressure 0xA0..0xA3
        start(W'('hA0), 4);
        repeat (6) step(100, 0);
        @(negedge clk);
        check("bp_accepted", 1, W'(4 - left[1]), W'(2));
        check("bp_accepted", 0, W'(4 - left[0]), W'(1));
        for (int d = 0; d < 2; d++) begin
            check("bp_in_ready", d, W'(in_ready[d]), W'(0));
            check("bp_dout", d, dout[d], W'('hA0));
        end
        drain();
        for (int d = 0; d < 2; d++) begin
            check("bp_count", d, W'(log_n[d]), W'(4));
            for (int k = 0; k < 4 && k < log_n[d]; k++)
                check("bp_word", d, log_w[d][k], W'('hA0 + k));
        end

        // reset while the skid buffer is full
        start(W'('hA0), 4);
        repeat (4) step(100, 0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            left[d] = 0;
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        log_n[0] = 0;
        log_n[1] = 0;
        repeat (10) step(100, 100);
        for (int d = 0; d < 2; d++) begin
            check("rst_full_out_valid", d, W'(out_valid[d]), W'(0));
            check("rst_full_no_stale", d, W'(log_n[d]), W'(0));
        end

        // randomized traffic
        rnd_data = 1'b1;
        start(W'({$urandom, $urandom}), 1000000);
        for (int b = 0; b < 24; b++) begin
            int pv;
            int pr;
            pv = $urandom_range(100, 20);
            pr = $urandom_range(100, 20);
            repeat (500) step(pv, pr);
        end
        left[0] = 0;
        left[1] = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
